// File: rtl/diff_averager.sv
// Decimating boxcar averager: block mean of 2^L valid samples, with PS register access.
// Optional per-block min/max tracking is enabled with the DIFF_AVG_MINMAX_EN macro.
module diff_averager #(
   parameter int DW       = 14,
   parameter int MAX_LOG2 = 12
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic signed [DW-1:0] dat_i,
   input  logic                 dat_valid_i,
   output logic signed [DW-1:0] out,
   output logic                 out_valid_o,
   input  logic [15:0]          addr,
   input  logic                 wen,
   input  logic                 ren,
   output logic                 ack,
   output logic [31:0]          rdata,
   input  logic [31:0]          wdata
);
   localparam int AW = DW + MAX_LOG2;
   localparam int CW = MAX_LOG2 + 1;

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t               state_reg, state_next;
   logic [3:0]           l_reg, l_next;
   logic signed [AW-1:0] acc_reg, acc_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic signed [DW-1:0] out_reg, out_next;
   logic                 out_valid_reg, out_valid_next;
   logic [31:0]          blk_reg, blk_next;
   logic                 sticky_reg, sticky_next;
   logic                 ack_reg, ack_next;
   logic [31:0]          rdata_reg, rdata_next;

   logic signed [AW-1:0] dat_ext, acc_sum, shifted;
   logic [CW-1:0]        cnt_inc, block_len;
   logic                 ctrl_wr, block_done;
   logic                 unused_wdata;

   assign dat_ext   = {{MAX_LOG2{dat_i[DW-1]}}, dat_i};
   assign acc_sum   = acc_reg + dat_ext;
   assign shifted   = acc_sum >>> l_reg;
   assign cnt_inc   = cnt_reg + CW'(1);
   assign block_len = CW'(1) << l_reg;
   assign ctrl_wr   = wen && (addr == 16'h0000);
   // A ctrl write discards the sample presented in the same cycle.
   assign block_done = !ctrl_wr && (state_reg == ACCUM) && dat_valid_i && (cnt_inc == block_len);
   assign unused_wdata = ^{wdata[31:9], wdata[7:4]};

`ifdef DIFF_AVG_MINMAX_EN
   logic signed [DW-1:0] min_run_reg, min_run_next, max_run_reg, max_run_next;
   logic signed [DW-1:0] min_reg, min_next, max_reg, max_next;
   logic signed [DW-1:0] min_s, max_s;
   // cnt==0 marks the first sample of a block, so trackers re-seed after any abort.
   assign min_s = (cnt_reg == '0 || dat_i < min_run_reg) ? dat_i : min_run_reg;
   assign max_s = (cnt_reg == '0 || dat_i > max_run_reg) ? dat_i : max_run_reg;
`endif

   always_comb begin
      state_next     = state_reg;
      l_next         = l_reg;
      acc_next       = acc_reg;
      cnt_next       = cnt_reg;
      out_next       = out_reg;
      out_valid_next = 1'b0;
      blk_next       = blk_reg;
      sticky_next    = sticky_reg;
      ack_next       = wen | ren;
      rdata_next     = 32'd0;
`ifdef DIFF_AVG_MINMAX_EN
      min_run_next   = min_run_reg;
      max_run_next   = max_run_reg;
      min_next       = min_reg;
      max_next       = max_reg;
`endif
      if (ctrl_wr) begin
         l_next     = (wdata[3:0] > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : wdata[3:0];
         state_next = wdata[8] ? ACCUM : IDLE;
         acc_next   = '0;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               acc_next = '0;
               cnt_next = '0;
            end
            ACCUM: begin
               if (dat_valid_i) begin
`ifdef DIFF_AVG_MINMAX_EN
                  min_run_next = min_s;
                  max_run_next = max_s;
`endif
                  if (block_done) begin
                     out_next       = shifted[DW-1:0];
                     out_valid_next = 1'b1;
                     blk_next       = blk_reg + 32'd1;
                     acc_next       = '0;
                     cnt_next       = '0;
`ifdef DIFF_AVG_MINMAX_EN
                     min_next       = min_s;
                     max_next       = max_s;
`endif
                  end else begin
                     acc_next = acc_sum;
                     cnt_next = cnt_inc;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
      // Reading the mean clears the sticky; a same-cycle completion wins.
      if (ren && addr == 16'h0004) sticky_next = 1'b0;
      if (block_done)              sticky_next = 1'b1;
      if (wen | ren) begin
         case (addr)
            16'h0000: rdata_next = {23'd0, state_next == ACCUM, 4'd0, l_next};
            16'h0004: rdata_next = {{(32-DW){out_reg[DW-1]}}, out_reg};
            16'h0008: rdata_next = blk_reg;
            16'h000C: rdata_next = {31'd0, sticky_reg};
`ifdef DIFF_AVG_MINMAX_EN
            16'h0010: rdata_next = {{(32-DW){min_reg[DW-1]}}, min_reg};
            16'h0014: rdata_next = {{(32-DW){max_reg[DW-1]}}, max_reg};
`endif
            default:  rdata_next = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= ACCUM;
         l_reg         <= 4'd0;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
         blk_reg       <= 32'd0;
         sticky_reg    <= 1'b0;
         ack_reg       <= 1'b0;
         rdata_reg     <= 32'd0;
`ifdef DIFF_AVG_MINMAX_EN
         min_run_reg   <= '0;
         max_run_reg   <= '0;
         min_reg       <= '0;
         max_reg       <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         l_reg         <= l_next;
         acc_reg       <= acc_next;
         cnt_reg       <= cnt_next;
         out_reg       <= out_next;
         out_valid_reg <= out_valid_next;
         blk_reg       <= blk_next;
         sticky_reg    <= sticky_next;
         ack_reg       <= ack_next;
         rdata_reg     <= rdata_next;
`ifdef DIFF_AVG_MINMAX_EN
         min_run_reg   <= min_run_next;
         max_run_reg   <= max_run_next;
         min_reg       <= min_next;
         max_reg       <= max_next;
`endif
      end
   end

   assign out         = out_reg;
   assign out_valid_o = out_valid_reg;
   assign ack         = ack_reg;
   assign rdata       = rdata_reg;
endmodule

// File: tb/tb_diff_averager.sv
// Directed self-checking bench for diff_averager; min/max checks follow DIFF_AVG_MINMAX_EN.
module tb_diff_averager;
   logic               clk_i = 1'b0;
   logic               rst_i = 1'b1;
   logic signed [13:0] dat_i = '0;
   logic               dat_valid_i = 1'b0;
   logic signed [13:0] out;
   logic               out_valid_o;
   logic [15:0]        addr = '0;
   logic               wen = 1'b0;
   logic               ren = 1'b0;
   logic               ack;
   logic [31:0]        rdata;
   logic [31:0]        wdata = '0;

   int checks = 0;
   int errors = 0;
   int pulses;
   logic [31:0] rd_val;

   diff_averager #(.DW(14), .MAX_LOG2(12)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .dat_valid_i(dat_valid_i),
      .out(out), .out_valid_o(out_valid_o), .addr(addr), .wen(wen), .ren(ren),
      .ack(ack), .rdata(rdata), .wdata(wdata)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] sx(input logic [13:0] v);
      return {{18{v[13]}}, v};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled on the following falling edge.
   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      addr = a; wdata = d; wen = 1'b1;
      tick();
      wen = 1'b0;
      chk("wr_ack", {31'd0, ack}, 32'd1);
      $display("write addr=%h data=%h", a, d);
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
      addr = a; ren = 1'b1;
      tick();
      ren = 1'b0;
      chk("rd_ack", {31'd0, ack}, 32'd1);
      chk(tag, rdata, exp);
      $display("read addr=%h data=%h", a, rdata);
   endtask

   task automatic feed(input int v, input logic exp_valid, input string tag);
      dat_i = 14'(v); dat_valid_i = 1'b1;
      tick();
      dat_valid_i = 1'b0;
      chk(tag, {31'd0, out_valid_o}, {31'd0, exp_valid});
      $display("sample %0d -> out_valid=%0d out=%0d", v, out_valid_o, out);
   endtask

   initial begin
      tick(); tick();
      chk("rst_out", sx(out), 32'd0);
      chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      rst_i = 1'b0;
      tick();
      rd_chk("ctrl_reset", 16'h0000, 32'h100);

      // L=0: registered pass-through, one pulse per sample
      for (int i = 0; i < 5; i++) begin
         feed(i, 1'b1, "l0_valid");
         chk("l0_out", sx(out), i);
      end
      tick();
      chk("l0_idle_valid", {31'd0, out_valid_o}, 32'd0);
      rd_chk("l0_blkcnt", 16'h0008, 32'd5);
      rd_chk("l0_mean", 16'h0004, 32'd4);
      rd_chk("l0_sticky_clr", 16'h000C, 32'd0);

      // L=2: 5,6,7,-2 -> 4 ; -1,-1,-1,-2 -> -2
      wr(16'h0000, 32'h102);
      rd_chk("ctrl_l2", 16'h0000, 32'h102);
      feed(5, 1'b0, "l2a_0"); feed(6, 1'b0, "l2a_1"); feed(7, 1'b0, "l2a_2");
      feed(-2, 1'b1, "l2a_end");
      chk("l2a_mean", sx(out), 32'd4);
      feed(-1, 1'b0, "l2b_0"); feed(-1, 1'b0, "l2b_1"); feed(-1, 1'b0, "l2b_2");
      feed(-2, 1'b1, "l2b_end");
      chk("l2b_mean", sx(out), 32'hFFFF_FFFE);

      // Gapped valid: valid at cycles 0,3,4,9 (values 1,2,3,6 -> mean 3); junk 100 elsewhere
      for (int c = 0; c < 10; c++) begin
         dat_valid_i = (c == 0 || c == 3 || c == 4 || c == 9);
         dat_i = (c == 0) ? 14'sd1 : (c == 3) ? 14'sd2 : (c == 4) ? 14'sd3 : (c == 9) ? 14'sd6 : 14'sd100;
         tick();
         chk("gap_valid", {31'd0, out_valid_o}, {31'd0, c == 9});
      end
      dat_valid_i = 1'b0;
      chk("gap_mean", sx(out), 32'd3);

      // L=12 full scale, both polarities
      wr(16'h0000, 32'h10C);
      pulses = 0;
      dat_i = 14'sd8191; dat_valid_i = 1'b1;
      for (int i = 0; i < 4096; i++) begin
         tick();
         pulses += int'(out_valid_o);
      end
      chk("l12_pos_pulses", pulses, 32'd1);
      chk("l12_pos_mean", sx(out), 32'd8191);
      pulses = 0;
      dat_i = -14'sd8192;
      for (int i = 0; i < 4096; i++) begin
         tick();
         pulses += int'(out_valid_o);
      end
      dat_valid_i = 1'b0;
      chk("l12_neg_pulses", pulses, 32'd1);
      chk("l12_neg_mean", sx(out), 32'hFFFF_E000);
      $display("L=12 blocks done out=%0d", out);
      wr(16'h0000, 32'h10F);
      rd_chk("ctrl_clamp", 16'h0000, 32'h10C);

      // Abort by ctrl write after 2 samples; the sample on the write cycle is discarded
      wr(16'h0000, 32'h102);
      feed(40, 1'b0, "abort_0"); feed(40, 1'b0, "abort_1");
      dat_i = 14'sd40; dat_valid_i = 1'b1;
      wr(16'h0000, 32'h102);
      dat_valid_i = 1'b0;
      chk("abort_wr_valid", {31'd0, out_valid_o}, 32'd0);
      feed(8, 1'b0, "fresh_0"); feed(8, 1'b0, "fresh_1"); feed(8, 1'b0, "fresh_2");
      feed(8, 1'b1, "fresh_end");
      chk("fresh_mean", sx(out), 32'd8);

      // Reset mid-block, with the completing sample presented alongside reset
      feed(5, 1'b0, "rstm_0"); feed(5, 1'b0, "rstm_1"); feed(5, 1'b0, "rstm_2");
      rst_i = 1'b1; dat_i = 14'sd5; dat_valid_i = 1'b1;
      tick();
      rst_i = 1'b0; dat_valid_i = 1'b0;
      chk("rstm_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rstm_out", sx(out), 32'd0);
      rd_chk("rstm_ctrl", 16'h0000, 32'h100);
      rd_chk("rstm_mean", 16'h0004, 32'd0);
      rd_chk("rstm_blk", 16'h0008, 32'd0);
      rd_chk("rstm_sticky", 16'h000C, 32'd0);

      // Sticky behaviour
      wr(16'h0000, 32'h102);
      for (int i = 0; i < 3; i++) feed(1, 1'b0, "st_fill");
      feed(1, 1'b1, "st_end");
      rd_chk("st_set", 16'h000C, 32'd1);
      rd_chk("st_mean", 16'h0004, 32'd1);
      rd_chk("st_cleared", 16'h000C, 32'd0);
      for (int i = 0; i < 3; i++) feed(2, 1'b0, "st2_fill");
      dat_i = 14'sd2; dat_valid_i = 1'b1; addr = 16'h0004; ren = 1'b1;
      tick();
      dat_valid_i = 1'b0; ren = 1'b0;
      chk("st2_ack", {31'd0, ack}, 32'd1);
      chk("st2_valid", {31'd0, out_valid_o}, 32'd1);
      chk("st2_mean", sx(out), 32'd2);
      rd_chk("st2_set_wins", 16'h000C, 32'd1);
      rd_chk("blk_after", 16'h0008, 32'd2);

`ifdef DIFF_AVG_MINMAX_EN
      feed(3, 1'b0, "mm_0"); feed(-7, 1'b0, "mm_1"); feed(12, 1'b0, "mm_2");
      feed(0, 1'b1, "mm_end");
      chk("mm_mean", sx(out), 32'd2);
      rd_chk("mm_min", 16'h0010, 32'hFFFF_FFF9);
      rd_chk("mm_max", 16'h0014, 32'd12);
`else
      rd_chk("unmapped_10", 16'h0010, 32'd0);
      rd_chk("unmapped_14", 16'h0014, 32'd0);
`endif
      rd_chk("unmapped_40", 16'h0040, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/diff_averager.md
Name: diff_averager

Overview:
- Downstream consumer of the 14-bit signed difference stage output.
- Accumulates blocks of 2^L consecutive valid samples and emits the block mean as a 14-bit signed value with a one-cycle valid strobe.
- Last mean, block counter and status are readable over the standard PS register bus; block length and enable are writable.
- Sits between the difference stage and the scope/PID inputs as a programmable decimating boxcar.

Parameters:
- DW, 14, input/output data width (signed).
- MAX_LOG2, 12, maximum log2 of block length; accumulator width is DW+MAX_LOG2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- dat_i  in  DW  signed sample from difference stage.
- dat_valid_i  in  1  sample qualifier; tie high for every-cycle data.
- out  out  DW  signed block mean, held between updates.
- out_valid_o  out  1  one-cycle pulse when out updates.
- addr  in  16  PS register address.
- wen  in  1  PS write strobe.
- ren  in  1  PS read strobe.
- ack  out  1  PS access acknowledge.
- rdata  out  32  PS read data.
- wdata  in  32  PS write data.

Behaviour:
- Reset values:
  - out=0, out_valid_o=0, ack=0, rdata=0.
  - accumulator=0, sample count=0, block count=0, sticky=0.
  - ctrl: enable=1, L=0.
- Registers:
  - 0x00 ctrl (RW): bits[3:0]=L, bit[8]=enable, other bits read 0. Written L>MAX_LOG2 is clamped to MAX_LOG2 and reads back clamped.
  - 0x04 mean (RO): out, sign-extended to 32 bits.
  - 0x08 block count (RO): 32-bit count of completed blocks, wraps 0xFFFFFFFF->0.
  - 0x0C status (RO): bit0=new-mean sticky.
  - Unmapped addresses read 0 and still ack.
- Bus handshake:
  - ack=1 exactly one cycle after any cycle with wen|ren; rdata is valid in that same cycle.
  - A write takes effect on the wen cycle.
  - Simultaneous wen and ren: write applied, single ack, rdata returns the post-write value.
- FSM states:
  - IDLE: enable=0. Accumulator and count held at 0. dat_i ignored. out holds its last value.
  - ACCUM: enable=1. On each dat_valid_i, acc+=sign_ext(dat_i) and cnt+=1.
- Block end:
  - When the sample making cnt==2^L is accepted, the next cycle has out=(acc_final)>>>L (arithmetic shift, floor toward -inf), out_valid_o=1, block count+=1, sticky=1.
  - acc and cnt restart from 0 in that same cycle, so there is no dead cycle: a valid sample on the restart cycle is the first sample of the new block.
- Latency: last sample of a block at cycle k -> out/out_valid_o at k+1. L=0 behaves as a registered pass-through with 1-cycle latency and a valid pulse per sample.
- Arithmetic: the accumulator is wide enough for 2^MAX_LOG2 full-scale samples, so overflow is impossible. The mean always fits DW bits, so no saturation is needed.
- Write to ctrl:
  - Any write to ctrl, whatever its value, aborts the partial block: acc=0, cnt=0 from the next cycle.
  - The sample present on the write cycle is discarded.
  - out and block count are unaffected.
- enable 1->0 mid-block: partial block discarded, no output pulse.
- Sticky: cleared by a read of 0x04. If a block completes in the same cycle as that read, set wins and sticky stays 1.
- rst_i mid-block: all state returns to reset values next cycle. No out_valid_o pulse, even if a block would have completed.

Optional Feature:
- Macro DIFF_AVG_MINMAX_EN.
- Defined:
  - Tracks per-block min and max of dat_i, signed.
  - Latched at block end together with out.
  - Readable at 0x10 (min) and 0x14 (max), sign-extended.
  - Reset to 0; trackers re-seed from the first sample of each block; abort rules match the accumulator.
- Undefined: no tracking logic; 0x10/0x14 read 0 like any unmapped address.

Test Plan:
- Reset, L=0, dat_i ramps 0,1,2,...: out equals the previous cycle's dat_i, out_valid_o high every cycle, block count increments by 1/cycle; 0x00 reads 0x100.
- Write ctrl=0x102 (L=2), feed 5,6,7,-2 continuous: one pulse 1 cycle after -2, out=4 (16>>>2); feed -1,-1,-1,-2: out=-2 (floor of -1.25).
- L=2, apply dat_valid_i gaps (valid on cycles 0,3,4,9): pulse only at cycle 10; samples on invalid cycles do not contribute.
- L=12, all samples 8191 then all -8192: out=8191 then -8192; no overflow. Write L=15: 0x00 reads back L=12.
- L=2, write ctrl after 2 samples of a block: no pulse for the partial block; next pulse only after 4 fresh samples. Assert rst_i mid-block: no pulse; all registers return to reset values.
- Sticky: complete a block, read 0x0C=1, read 0x04 -> 0x0C=0. Make a block complete on the 0x04 read cycle -> 0x0C stays 1. With DIFF_AVG_MINMAX_EN defined, block 3,-7,12,0 -> 0x10=-7 (0xFFFFFFF9), 0x14=12.
